// File: rtl/bpsk_deinterleaver_pkg.sv
// Geometry shared by the 6 Mbps (BPSK) interleaver/deinterleaver pair.
package bpsk_deinterleaver_pkg;
  localparam int N_CBPS = 48;
  localparam int N_COL  = 16;
  localparam int N_ROW  = N_CBPS / N_COL;
  localparam int ADDR_W = $clog2(N_CBPS);
  localparam int ROW_W  = 2;
  localparam int COL_W  = $clog2(N_COL);

  // Bank address of a received bit, given its row/column position.
  function automatic logic [ADDR_W-1:0] deint_addr(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] q);
    return ADDR_W'(int'(r) * N_COL + int'(q));
  endfunction
endpackage

// File: rtl/bpsk_deinterleaver_addr_gen.sv
// Write-address generator: k = N_COL*r + q walked with row/column counters.
module deint_addr_gen
  import bpsk_deinterleaver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ROW_W-1:0] r;
  logic [COL_W-1:0] q;

  assign addr = deint_addr(r, q);
  assign last = (r == ROW_W'(N_ROW - 1)) && (q == COL_W'(N_COL - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r <= '0;
      q <= '0;
    end else if (adv) begin
      if (r == ROW_W'(N_ROW - 1)) begin
        r <= '0;
        q <= last ? '0 : q + 1'b1;
      end else begin
        r <= r + 1'b1;
      end
    end
  end
endmodule

// File: rtl/bpsk_deinterleaver.sv
// BPSK block deinterleaver: ping-pong banks, one symbol fills while the other drains.
module bpsk_deinterleaver
  import bpsk_deinterleaver_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic Start,
  input  logic In_Valid,
  input  logic Input,
  input  logic Out_Ready,
  output logic Out_Valid,
  output logic Output,
  output logic Error
);
  localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(N_CBPS - 1);

  if (N_ROW != 3 || N_ROW * N_COL != N_CBPS) begin : g_bad_geometry
    $error("bpsk_deinterleaver: N_CBPS/N_COL must be exactly 3");
  end

  logic [1:0][N_CBPS-1:0] bank;
  logic [1:0]             full, full_n;
  logic                   wb, rb, rb_n;
  logic [ADDR_W-1:0]      rp, rp_n, wr_addr;
  logic                   wr_last, accept, overflow, pop;

  // Start outranks a coincident input bit.
  assign accept   = In_Valid && !Start && !full[wb];
  assign overflow = In_Valid && !Start && full[wb];
  assign pop      = Out_Valid && Out_Ready;

  deint_addr_gen u_addr (
    .clk  (Clock),
    .rst_n(Reset),
    .clr  (Start),
    .adv  (accept),
    .addr (wr_addr),
    .last (wr_last)
  );

  // Completion and release always hit different banks, so both can apply.
  always_comb begin
    full_n = full;
    rb_n   = rb;
    rp_n   = rp;
    if (pop) begin
      if (rp == LAST_K) begin
        full_n[rb] = 1'b0;
        rb_n       = ~rb;
        rp_n       = '0;
      end else begin
        rp_n = rp + 1'b1;
      end
    end
    if (accept && wr_last) full_n[wb] = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (accept) bank[wb][wr_addr] <= Input;
  end

  // Output is prefetched from next-state pointers so valid data is present
  // the cycle after the last bit of a symbol lands.
  always_ff @(posedge Clock) begin
    if (!Reset || Start) begin
      full      <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      rp        <= '0;
      Out_Valid <= 1'b0;
      Output    <= 1'b0;
      Error     <= 1'b0;
    end else begin
      full      <= full_n;
      rb        <= rb_n;
      rp        <= rp_n;
      if (accept && wr_last) wb <= ~wb;
      if (overflow) Error <= 1'b1;
      Out_Valid <= full_n[rb_n];
      Output    <= full_n[rb_n] & bank[rb_n][rp_n];
    end
  end
endmodule

// File: tb/tb_bpsk_deinterleaver.sv
// Directed bench for bpsk_deinterleaver with a reference inverse permutation.
module tb_bpsk_deinterleaver;
  logic Clock, Reset, Start, In_Valid, Input, Out_Ready;
  logic Out_Valid, Output, Error;

  int errors = 0;
  int checks = 0;
  int tgl    = 0;
  logic outq[$];
  logic expq[$];

  bpsk_deinterleaver dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .In_Valid (In_Valid),
    .Input    (Input),
    .Out_Ready(Out_Ready),
    .Out_Valid(Out_Valid),
    .Output   (Output),
    .Error    (Error)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Output k carries the received bit i with k = 16*(i%3) + i/3, i.e. i = 3*(k%16) + k/16.
  function automatic logic exp_bit(input logic [47:0] s, input int k);
    return s[3 * (k % 16) + k / 16];
  endfunction

  task automatic push_sym(input logic [47:0] s);
    for (int k = 0; k < 48; k++) expq.push_back(exp_bit(s, k));
  endtask

  function automatic logic rdy_of(input int mode, input int c);
    return (mode == 2) ? logic'(c % 2) : logic'(mode == 1);
  endfunction

  // One clock: drive inputs, log a bit if it will be accepted at this edge.
  task automatic cyc(input logic iv, input logic ib, input logic rdy);
    In_Valid  = iv;
    Input     = ib;
    Out_Ready = rdy;
    if (Out_Valid && rdy) outq.push_back(Output);
    @(posedge Clock);
    #1;
  endtask

  task automatic send(input logic [47:0] s, input int mode);
    for (int i = 0; i < 48; i++) begin
      cyc(1'b1, s[i], rdy_of(mode, tgl));
      tgl++;
    end
  endtask

  task automatic drain(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      cyc(1'b0, 1'b0, rdy_of(mode, tgl));
      tgl++;
    end
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_count"}, outq.size(), expq.size());
    for (int k = 0; k < expq.size(); k++)
      chk($sformatf("%s_bit%0d", tag, k), (k < outq.size()) ? outq[k] : 1'bx, expq[k]);
    outq.delete();
    expq.delete();
  endtask

  initial begin
    logic [47:0] s1, s2, a, b, c, d, f, g, h, ii;
    logic [47:0] s3[3];
    int vcount;
    bit seen, gap;

    Reset = 1'b0; Start = 1'b0; In_Valid = 1'b0; Input = 1'b0; Out_Ready = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_out_valid", Out_Valid, 0);
    chk("rst_output", Output, 0);
    chk("rst_error", Error, 0);
    Reset = 1'b1;
    Start = 1'b1;
    cyc(1'b0, 1'b0, 1'b1);
    Start = 1'b0;

    // T1: single 1 at i=1 lands at k=16; latency check around bit 47.
    s1 = 48'h0;
    s1[1] = 1'b1;
    for (int i = 0; i < 48; i++) begin
      cyc(1'b1, s1[i], 1'b1);
      if (i == 46) chk("t1_lat_pre", Out_Valid, 0);
      if (i == 47) chk("t1_lat", Out_Valid, 1);
    end
    drain(48, 1);
    chk("t1_done", Out_Valid, 0);
    for (int k = 0; k < 48; k++) expq.push_back(k == 16);
    check_q("t1");

    // T2: every third bit set -> first 16 outputs are 1.
    for (int i = 0; i < 48; i++) s2[i] = (i % 3 == 0);
    send(s2, 1);
    drain(48, 1);
    for (int k = 0; k < 48; k++) expq.push_back(k < 16);
    check_q("t2");

    // T3: three back-to-back symbols stream out with no bubbles.
    s3[0] = 48'hA5C3_1F0E_9B27;
    s3[1] = 48'h3C96_E701_5AD4;
    s3[2] = 48'hFFFF_0000_C0DE;
    vcount = 0; seen = 0; gap = 0;
    for (int cc = 0; cc < 200; cc++) begin
      if (Out_Valid) begin vcount++; seen = 1; end
      else if (seen && vcount < 144) gap = 1;
      cyc(cc < 144, (cc < 144) ? s3[cc / 48][cc % 48] : 1'b0, 1'b1);
    end
    chk("t3_valid_cycles", vcount, 144);
    chk("t3_gap", gap, 0);
    chk("t3_error", Error, 0);
    for (int sidx = 0; sidx < 3; sidx++) push_sym(s3[sidx]);
    check_q("t3");

    // T4: reader stalled for two symbols, one extra bit overflows and is dropped.
    a = 48'h1234_5678_9ABC;
    b = 48'hF0E1_D2C3_B4A5;
    c = 48'h0F1E_2D3C_4B5A;
    send(a, 0);
    send(b, 0);
    chk("t4_pre_err", Error, 0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t4_err", Error, 1);
    chk("t4_valid", Out_Valid, 1);
    drain(96, 1);
    chk("t4_drained", Out_Valid, 0);
    push_sym(a);
    push_sym(b);
    check_q("t4_ab");
    send(c, 1);
    drain(48, 1);
    push_sym(c);
    check_q("t4_c");
    chk("t4_sticky", Error, 1);

    // T5: Start at i=20 with a full undrained bank pending.
    d = 48'hDEAD_BEEF_CAFE;
    f = 48'h5A5A_C3C3_0FF0;
    send(d, 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
    Start = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    Start = 1'b0;
    chk("t5_valid", Out_Valid, 0);
    chk("t5_error", Error, 0);
    chk("t5_output", Output, 0);
    send(f, 1);
    drain(48, 1);
    chk("t5_done", Out_Valid, 0);
    push_sym(f);
    check_q("t5");

    // T6: reset while draining at rp=10.
    g = '1;
    h = 48'h8421_1248_7E81;
    send(g, 1);
    drain(10, 1);
    Reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    Reset = 1'b1;
    outq.delete();
    chk("t6_valid", Out_Valid, 0);
    chk("t6_output", Output, 0);
    chk("t6_error", Error, 0);
    send(h, 1);
    drain(48, 1);
    push_sym(h);
    check_q("t6");

    // T7: Out_Ready toggling during drain.
    ii = 48'h6B2F_91D0_E35C;
    send(ii, 2);
    drain(110, 2);
    chk("t7_done", Out_Valid, 0);
    push_sym(ii);
    check_q("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
